cci_mpf_fiu_responder: RTL and testbench

CCI_MPF_FIU_RESPONDER -- requirements
Module: cci_mpf_fiu_responder

---
 rtl/cci_mpf_fiu_responder_if.sv | 35 +++
 rtl/cci_mpf_fiu_responder.sv | 158 +++++++++++++++
 tb/tb_cci_mpf_fiu_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_fiu_responder_if.sv
// CCI-style request/response bundle between an AFU-side master and the FIU responder.
// Carries both request channels, both response channels and the overflow flag.
interface cci_mpf_fiu_responder_if;
  logic         c0_tx_valid;
  logic [41:0]  c0_tx_addr;
  logic [15:0]  c0_tx_mdata;
  logic         c0_tx_alm_full;
  logic         c1_tx_valid;
  logic [41:0]  c1_tx_addr;
  logic [15:0]  c1_tx_mdata;
  logic [511:0] c1_tx_data;
  logic         c1_tx_alm_full;
  logic         c0_rx_valid;
  logic [15:0]  c0_rx_mdata;
  logic [511:0] c0_rx_data;
  logic         c1_rx_valid;
  logic [15:0]  c1_rx_mdata;
  logic         ovf_err;

  modport master (
    output c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    output c1_tx_valid, c1_tx_addr, c1_tx_mdata, c1_tx_data,
    input  c0_tx_alm_full, c1_tx_alm_full,
    input  c0_rx_valid, c0_rx_mdata, c0_rx_data,
    input  c1_rx_valid, c1_rx_mdata, ovf_err
  );

  modport slave (
    input  c0_tx_valid, c0_tx_addr, c0_tx_mdata,
    input  c1_tx_valid, c1_tx_addr, c1_tx_mdata, c1_tx_data,
    output c0_tx_alm_full, c1_tx_alm_full,
    output c0_rx_valid, c0_rx_mdata, c0_rx_data,
    output c1_rx_valid, c1_rx_mdata, ovf_err
  );
endinterface

// File: rtl/cci_mpf_fiu_responder.sv
// Fixed-latency FIU responder: per-channel timestamped FIFOs, in-order replies.
// Optional macro CCI_MPF_FIU_RESP_CHECK_EN makes dropped requests set sticky ovf_err.
module cci_mpf_fiu_resp_chan #(
  parameter int FIFO_LOG      = 4,
  parameter int LATENCY       = 8,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] now_i,
  input  logic        valid_i,
  input  logic [41:0] addr_i,
  input  logic [15:0] mdata_i,
  output logic        deq_o,
  output logic [41:0] head_addr_o,
  output logic        drop_o,
  output logic        alm_full_o,
  output logic        rx_valid_o,
  output logic [15:0] rx_mdata_o
);
  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int CW    = FIFO_LOG + 1;

  logic [41:0]         addr_mem  [DEPTH];
  logic [15:0]         mdata_mem [DEPTH];
  logic [15:0]         stamp_mem [DEPTH];
  logic [FIFO_LOG-1:0] wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                alm_q, alm_d;
  logic                vld_q;
  logic [15:0]         mdata_q;
  logic                full, enq;
  logic [15:0]         age;

  // Full is judged on occupancy before this edge's dequeue.
  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    enq    = valid_i & ~full;
    drop_o = valid_i & full;
    age    = now_i - stamp_mem[rd_q];
    deq_o  = (cnt_q != '0) && (age >= 16'(LATENCY));
    cnt_d  = cnt_q + CW'(enq) - CW'(deq_o);
    alm_d  = (cnt_d >= CW'(DEPTH - ALMFULL_SLACK));
  end

  assign head_addr_o = addr_mem[rd_q];

  // Storage only; pointers and count carry validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_q]  <= addr_i;
      mdata_mem[wr_q] <= mdata_i;
      stamp_mem[wr_q] <= now_i;
    end
  end

  // Pointer/occupancy bookkeeping and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      alm_q   <= 1'b0;
      vld_q   <= 1'b0;
      mdata_q <= '0;
    end else begin
      if (enq)   wr_q <= wr_q + 1'b1;
      if (deq_o) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      alm_q <= alm_d;
      vld_q <= deq_o;
      if (deq_o) mdata_q <= mdata_mem[rd_q];
    end
  end

  assign alm_full_o = alm_q;
  assign rx_valid_o = vld_q;
  assign rx_mdata_o = mdata_q;
endmodule

module cci_mpf_fiu_responder #(
  parameter int FIFO_LOG      = 4,
  parameter int LATENCY       = 8,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic clk,
  input  logic reset_n,
  cci_mpf_fiu_responder_if.slave bus
);
  logic [15:0]  now_q;
  logic         deq0, deq1, drop0, drop1;
  logic [41:0]  head0, head1;
  logic [511:0] data_d, data_q;
  logic         unused_bits;

  // Free-running timestamp source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) now_q <= '0;
    else          now_q <= now_q + 16'd1;
  end

  cci_mpf_fiu_resp_chan #(
    .FIFO_LOG(FIFO_LOG), .LATENCY(LATENCY),
    .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c0 (
    .clk(clk), .reset_n(reset_n), .now_i(now_q),
    .valid_i(bus.c0_tx_valid), .addr_i(bus.c0_tx_addr),
    .mdata_i(bus.c0_tx_mdata), .deq_o(deq0),
    .head_addr_o(head0), .drop_o(drop0),
    .alm_full_o(bus.c0_tx_alm_full),
    .rx_valid_o(bus.c0_rx_valid),
    .rx_mdata_o(bus.c0_rx_mdata)
  );

  cci_mpf_fiu_resp_chan #(
    .FIFO_LOG(FIFO_LOG), .LATENCY(LATENCY),
    .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c1 (
    .clk(clk), .reset_n(reset_n), .now_i(now_q),
    .valid_i(bus.c1_tx_valid), .addr_i(bus.c1_tx_addr),
    .mdata_i(bus.c1_tx_mdata), .deq_o(deq1),
    .head_addr_o(head1), .drop_o(drop1),
    .alm_full_o(bus.c1_tx_alm_full),
    .rx_valid_o(bus.c1_rx_valid),
    .rx_mdata_o(bus.c1_rx_mdata)
  );

  // Read data: every 64-bit word is the line address tagged with its index.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < 8; i++)
      data_d[i*64 +: 64] = {head0, 19'b0, 3'(i)};
  end

  // Capture read data only when a read response issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  data_q <= '0;
    else if (deq0) data_q <= data_d;
  end

  assign bus.c0_rx_data = data_q;

`ifdef CCI_MPF_FIU_RESP_CHECK_EN
  logic ovf_q;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_q | drop0 | drop1;
  end

  assign bus.ovf_err = ovf_q;
  assign unused_bits = ^{bus.c1_tx_data, head1, deq1};
`else
  assign bus.ovf_err = 1'b0;
  assign unused_bits = ^{bus.c1_tx_data, head1, deq1, drop0, drop1};
`endif
endmodule

// File: tb/tb_cci_mpf_fiu_responder.sv
// Self-checking bench for cci_mpf_fiu_responder against a queue-based model.
// Directed phases with randomized payloads; checks every cycle.
module tb_cci_mpf_fiu_responder;
  localparam int LAT   = 16;
  localparam int DEPTH = 16;
  localparam int ALM   = DEPTH - 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cci_mpf_fiu_responder_if bus();

  cci_mpf_fiu_responder #(
    .FIFO_LOG(4), .LATENCY(LAT), .ALMFULL_SLACK(4)
  ) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic [41:0] addr;
    logic [15:0] tag;
    int          t;
  } req_t;

  req_t q0[$];
  req_t q1[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic         e0v, e1v, e0alm, e1alm, eovf;
  logic [15:0]  e0tag, e1tag;
  logic [511:0] e0data;

  function automatic logic [511:0] rd_data(logic [41:0] a);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      d[i*64 +: 64] = (64'(a) << 22) + 64'(i);
    return d;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    e0v = 0; e1v = 0; e0alm = 0; e1alm = 0; eovf = 0;
    e0tag = '0; e1tag = '0; e0data = '0;
    cyc = 0;
  endtask

  // One rising edge of behaviour: oldest-first retire after LAT cycles,
  // accept only if the queue was not already full before retiring.
  task automatic model_edge();
    int s;
    req_t r;
    s = q0.size();
    e0v = 0;
    if (s > 0 && cyc - q0[0].t >= LAT) begin
      r = q0.pop_front();
      e0v = 1; e0tag = r.tag; e0data = rd_data(r.addr);
    end
    if (bus.c0_tx_valid) begin
      if (s == DEPTH) begin
`ifdef CCI_MPF_FIU_RESP_CHECK_EN
        eovf = 1;
`endif
      end else begin
        q0.push_back('{bus.c0_tx_addr, bus.c0_tx_mdata, cyc});
      end
    end
    e0alm = (q0.size() >= ALM);
    s = q1.size();
    e1v = 0;
    if (s > 0 && cyc - q1[0].t >= LAT) begin
      r = q1.pop_front();
      e1v = 1; e1tag = r.tag;
    end
    if (bus.c1_tx_valid) begin
      if (s == DEPTH) begin
`ifdef CCI_MPF_FIU_RESP_CHECK_EN
        eovf = 1;
`endif
      end else begin
        q1.push_back('{bus.c1_tx_addr, bus.c1_tx_mdata, cyc});
      end
    end
    e1alm = (q1.size() >= ALM);
    cyc++;
  endtask

  task automatic check_all();
    chk("c0_rx_valid", 512'(bus.c0_rx_valid), 512'(e0v));
    chk("c0_rx_mdata", 512'(bus.c0_rx_mdata), 512'(e0tag));
    chk("c0_rx_data", bus.c0_rx_data, e0data);
    chk("c1_rx_valid", 512'(bus.c1_rx_valid), 512'(e1v));
    chk("c1_rx_mdata", 512'(bus.c1_rx_mdata), 512'(e1tag));
    chk("c0_alm_full", 512'(bus.c0_tx_alm_full), 512'(e0alm));
    chk("c1_alm_full", 512'(bus.c1_tx_alm_full), 512'(e1alm));
    chk("ovf_err", 512'(bus.ovf_err), 512'(eovf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(bit v0, bit v1);
    bus.c0_tx_valid = v0;
    bus.c0_tx_addr  = 42'({$urandom(), $urandom()});
    bus.c0_tx_mdata = 16'($urandom());
    bus.c1_tx_valid = v1;
    bus.c1_tx_addr  = 42'({$urandom(), $urandom()});
    bus.c1_tx_mdata = 16'($urandom());
    for (int i = 0; i < 16; i++)
      bus.c1_tx_data[i*32 +: 32] = $urandom();
  endtask

  task automatic idle(int n);
    drive(0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    drive(1, 1);
    for (int i = 0; i < n; i++) step();
    drive(0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    drive(0, 0);
    #2;
    check_all();
    do_reset(3);

    // Single read at edge 10.
    while (cyc < 10) step();
    drive(0, 0);
    bus.c0_tx_valid = 1'b1;
    bus.c0_tx_addr  = 42'h1;
    bus.c0_tx_mdata = 16'hA5;
    step();
    idle(LAT + 4);
    chk("single_rd_word3", 512'(bus.c0_rx_data[3*64 +: 64]),
        512'(64'h0000_0000_0040_0003));

    // Sixteen back-to-back writes with tags 0..15.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1);
      bus.c1_tx_mdata = 16'(i);
      step();
    end
    idle(LAT + 20);

    // Random sparse traffic on both channels.
    for (int i = 0; i < 300; i++)
      begin drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))); step(); end
    idle(LAT + 20);

    // Seventeen consecutive reads: the last hits a full FIFO.
    for (int i = 0; i < 17; i++) begin drive(1, 0); step(); end
    idle(LAT + 20);

    // Both channels every cycle for 100 cycles.
    for (int i = 0; i < 100; i++) begin drive(1, 1); step(); end
    idle(LAT + 20);

    // Reset with five reads outstanding.
    for (int i = 0; i < 5; i++) begin drive(1, 0); step(); end
    idle(2);
    do_reset(3);
    idle(LAT + 20);

    // Traffic straddling the 16-bit timestamp wrap.
    drive(0, 0);
    while (cyc < 65520) begin @(posedge clk); model_edge(); end
    #1;
    check_all();
    for (int i = 0; i < 40; i++)
      begin drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))); step(); end
    idle(LAT + 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
